// File: rtl/add_seq_ctrl_pkg.sv
// rtl/add_seq_ctrl_pkg.sv - shared state encoding and defaults for add_seq_ctrl
// Purpose: holds the controller state enum and the default nibble count so the
//          top and any future siblings agree on encodings.
// Contents:
//   NNIB_DEFAULT : default number of 4-bit nibbles per operand
//   state_e      : IDLE=0, RUN=1, DONE=2
//   idx_width()  : width of the nibble index, ceil(log2(nnib)) with a minimum of 1
package add_seq_ctrl_pkg;

  localparam int NNIB_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int idx_width(input int nnib);
    return (nnib > 1) ? $clog2(nnib) : 1;
  endfunction

endpackage

// File: rtl/add4c_v.sv
// rtl/add4c_v.sv - combinational 4-bit adder slice with carry-in and carry-out
// Purpose: the single shared nibble adder used by add_seq_ctrl.
// Ports:
//   iA, iB : 4-bit addends
//   iCi    : carry in
//   oS     : 4-bit sum
//   oCo    : carry out of bit 3
module add4c_v (
  input  logic [3:0] iA,
  input  logic [3:0] iB,
  input  logic       iCi,
  output logic [3:0] oS,
  output logic       oCo
);

  logic [4:0] sum5;

  assign sum5 = {1'b0, iA} + {1'b0, iB} + {4'b0000, iCi};
  assign oS   = sum5[3:0];
  assign oCo  = sum5[4];

endmodule

// File: rtl/add_seq_ctrl.sv
// rtl/add_seq_ctrl.sv - nibble-serial adder/subtractor controller
// Purpose: computes A+B or A-B one nibble per cycle, LSB first, through a single
//          shared 4-bit slice, then presents the full result with carry and
//          signed overflow.
// Ports:
//   iCLK      : clock, rising edge
//   iRST      : asynchronous active-high reset
//   iStart    : start request, sampled only in IDLE
//   iSub      : 0 = A+B, 1 = A-B
//   iA, iB    : W-bit operands (W = 4*NNIB)
//   oBusy     : high whenever the state is not IDLE
//   oDone     : one-cycle completion pulse
//   oResult   : sum or difference, held until the next accepted start
//   oCarry    : raw final carry out of the MSB nibble (1 = no borrow on subtract)
//   oOverflow : signed two's-complement overflow
module add_seq_ctrl
  import add_seq_ctrl_pkg::*;
#(
  parameter int NNIB = NNIB_DEFAULT
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iStart,
  input  logic              iSub,
  input  logic [4*NNIB-1:0] iA,
  input  logic [4*NNIB-1:0] iB,
  output logic              oBusy,
  output logic              oDone,
  output logic [4*NNIB-1:0] oResult,
  output logic              oCarry,
  output logic              oOverflow
);

  localparam int W  = 4 * NNIB;
  localparam int KW = idx_width(NNIB);
  localparam logic [KW-1:0] LAST_IDX = KW'(NNIB - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            sub_q, sub_d;
  logic            cy_q, cy_d;
  logic [KW-1:0]   idx_q, idx_d;
  logic [W-1:0]    acc_q, acc_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [W-1:0]    result_q, result_d;
  logic            carry_q, carry_d;
  logic            ovf_q, ovf_d;

  logic [W-1:0]    a_sh, b_sh;
  logic [3:0]      a_nib, b_nib, nib_sum;
  logic            nib_ci, nib_co;
  logic [W-1:0]    acc_shift;

  // Select the current nibble by shifting rather than a variable part-select.
  assign a_sh  = a_q >> {idx_q, 2'b00};
  assign b_sh  = b_q >> {idx_q, 2'b00};
  assign a_nib = a_sh[3:0];
  assign b_nib = b_sh[3:0];

  // The first nibble takes the latched operation bit as its carry-in (the +1
  // of two's-complement subtraction); later nibbles chain the carry register.
  assign nib_ci = (idx_q == '0) ? sub_q : cy_q;

  add4c_v u_slice (
    .iA  (a_nib),
    .iB  (b_nib),
    .iCi (nib_ci),
    .oS  (nib_sum),
    .oCo (nib_co)
  );

  // Partial result fills from the top: after NNIB shifts nibble 0 sits at the LSB.
  assign acc_shift = (acc_q >> 4) | (W'(nib_sum) << (W - 4));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    cy_d     = cy_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    done_d   = 1'b0;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          state_d = ST_RUN;
          a_d     = iA;
          b_d     = iSub ? ~iB : iB;
          sub_d   = iSub;
          cy_d    = iSub;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      ST_RUN: begin
        acc_d = acc_shift;
        cy_d  = nib_co;
        if (idx_q == LAST_IDX) begin
          state_d  = ST_DONE;
          idx_d    = '0;
          done_d   = 1'b1;
          result_d = acc_shift;
          carry_d  = nib_co;
          // MSBs of A and B' live in bit 3 of the final nibble.
          ovf_d    = (a_nib[3] == b_nib[3]) && (nib_sum[3] != a_nib[3]);
        end else begin
          idx_d = idx_q + KW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      cy_q     <= 1'b0;
      idx_q    <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      cy_q     <= cy_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign oBusy     = busy_q;
  assign oDone     = done_q;
  assign oResult   = result_q;
  assign oCarry    = carry_q;
  assign oOverflow = ovf_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb/tb_add_seq_ctrl.sv - self-checking bench for add_seq_ctrl
module tb_add_seq_ctrl;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iStart = 1'b0;
  logic        iSub = 1'b0;
  logic [15:0] iA = '0;
  logic [15:0] iB = '0;
  logic        oBusy, oDone, oCarry, oOverflow;
  logic [15:0] oResult;

  int checks = 0;
  int failures = 0;

  add_seq_ctrl #(.NNIB(4)) dut (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iStart    (iStart),
    .iSub      (iSub),
    .iA        (iA),
    .iB        (iB),
    .oBusy     (oBusy),
    .oDone     (oDone),
    .oResult   (oResult),
    .oCarry    (oCarry),
    .oOverflow (oOverflow)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        cy;
    logic        ov;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  // Drive one operation; lat counts edges from the accepting edge (=1) to the
  // edge after which oDone is seen high.
  task automatic run_op(input logic sub, input logic [15:0] a, input logic [15:0] b,
                        output int lat);
    iA = a; iB = b; iSub = sub; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    iA = 16'hDEAD; iB = 16'hBEEF; iSub = ~sub;
    lat = 1;
    while (!oDone && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int pulses;
    int gap;
    int idle_cnt;

    vecs[0] = '{1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 16'h0F0F, 16'h00F1, 16'h1000, 1'b0, 1'b0};

    // Reset state while reset is held.
    #12;
    check("rst_busy", 32'(oBusy), 32'd0);
    check("rst_done", 32'(oDone), 32'd0);
    check("rst_result", 32'(oResult), 32'd0);
    check("rst_carry", 32'(oCarry), 32'd0);
    check("rst_ovf", 32'(oOverflow), 32'd0);
    @(negedge iCLK);
    iRST = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].sub, vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd5);
      check($sformatf("v%0d_result", i), 32'(oResult), 32'(vecs[i].res));
      check($sformatf("v%0d_carry", i), 32'(oCarry), 32'(vecs[i].cy));
      check($sformatf("v%0d_ovf", i), 32'(oOverflow), 32'(vecs[i].ov));
      check($sformatf("v%0d_busy_in_done", i), 32'(oBusy), 32'd1);
      tick();
      check($sformatf("v%0d_done_one_cycle", i), 32'(oDone), 32'd0);
      check($sformatf("v%0d_busy_after", i), 32'(oBusy), 32'd0);
      tick();
      check($sformatf("v%0d_result_hold", i), 32'(oResult), 32'(vecs[i].res));
    end

    // Start during RUN is ignored.
    iA = 16'h1234; iB = 16'h4321; iSub = 1'b0; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    tick();
    iA = 16'h1111; iB = 16'h0000; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      if (oDone) begin
        pulses++;
        check("busy_start_result", 32'(oResult), 32'h5555);
      end
      tick();
    end
    check("busy_start_pulses", 32'(pulses), 32'd1);
    check("busy_start_hold", 32'(oResult), 32'h5555);

    // Reset mid-RUN aborts without a done pulse.
    iA = 16'h2222; iB = 16'h3333; iSub = 1'b0; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    tick();
    iRST = 1'b1;
    #1;
    check("midrst_busy", 32'(oBusy), 32'd0);
    check("midrst_result", 32'(oResult), 32'd0);
    check("midrst_carry", 32'(oCarry), 32'd0);
    check("midrst_ovf", 32'(oOverflow), 32'd0);
    tick();
    iRST = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      if (oDone) pulses++;
      tick();
    end
    check("midrst_no_done", 32'(pulses), 32'd0);
    run_op(1'b0, 16'h0001, 16'h0002, lat);
    check("postrst_latency", 32'(lat), 32'd5);
    check("postrst_result", 32'(oResult), 32'h0003);
    tick();
    tick();

    // iStart held high: DONE, one IDLE cycle, then the next RUN.
    iA = 16'h0101; iB = 16'h0202; iSub = 1'b0; iStart = 1'b1;
    lat = 0;
    while (!oDone && lat < 20) begin
      tick();
      lat++;
    end
    check("b2b_first_done", 32'(oDone), 32'd1);
    gap = 0;
    idle_cnt = 0;
    do begin
      tick();
      gap++;
      if (!oBusy) idle_cnt++;
    end while (!oDone && gap < 20);
    iStart = 1'b0;
    check("b2b_gap", 32'(gap), 32'd6);
    check("b2b_idle_cycles", 32'(idle_cnt), 32'd1);
    check("b2b_result", 32'(oResult), 32'h0303);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
